// File: rtl/cartoon_edge_detect.sv
// Streaming Sobel edge detector: RGB -> luma, two line buffers feeding a 3x3 window,
// thresholded |Gx|+|Gy| flag, with a 24-bit side channel kept in lock-step (3-cycle latency).
module cartoon_edge_detect #(
    parameter int WIDTH = 640,
    parameter int XW    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    input  logic [7:0]  thresh,
    output logic        out_valid,
    output logic [7:0]  edge_out,
    input  logic [23:0] pass_in,
    output logic [23:0] pass_thru
);

    logic               r_s1_valid;
    logic               r_s1_sof;
    logic [7:0]         r_s1_y;
    logic [23:0]        r_s1_pass;
    logic [15:0]        w_luma_sum;

    logic [XW-1:0]      r_x;
    logic [XW-1:0]      w_x_eff;
    logic [XW-1:0]      w_x_next;
    logic [1:0]         r_rc;
    logic [1:0]         w_rc_eff;
    logic [1:0]         w_rc_next;
    logic [1:0]         w_wcol;
    logic [1:0]         r_s2_wcol;
    logic [1:0]         r_s2_rc;
    logic               r_s2_valid;
    logic [23:0]        r_s2_pass;

    logic [7:0]         r_lb0 [WIDTH];
    logic [7:0]         r_lb1 [WIDTH];
    logic [7:0]         w_lb0_rd;
    logic [7:0]         w_lb1_rd;
    logic [7:0]         r_win [3][3];

    logic [9:0]         w_gx_pos;
    logic [9:0]         w_gx_neg;
    logic [9:0]         w_gy_pos;
    logic [9:0]         w_gy_neg;
    logic signed [10:0] w_gx;
    logic signed [10:0] w_gy;
    logic [10:0]        w_gx_abs;
    logic [10:0]        w_gy_abs;
    logic [11:0]        w_mag;
    logic               w_edge;

    // Luma weights sum to 256, so white maps exactly to 255 without overflowing 16 bits.
    always_comb begin
        w_luma_sum = 16'd77 * {8'd0, r} + 16'd150 * {8'd0, g} + 16'd29 * {8'd0, b};
    end

    // S1 register: luma plus qualifiers and side channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sof   <= 1'b0;
            r_s1_y     <= 8'd0;
            r_s1_pass  <= 24'd0;
        end else begin
            r_s1_valid <= in_valid;
            r_s1_sof   <= in_valid & in_sof;
            r_s1_y     <= w_luma_sum[15:8];
            r_s1_pass  <= pass_in;
        end
    end

    // S2 addressing: sof restarts position for this very pixel; row count saturates at 2.
    always_comb begin
        w_x_eff  = r_s1_sof ? {XW{1'b0}} : r_x;
        w_rc_eff = r_s1_sof ? 2'd0 : r_rc;
        w_lb0_rd = r_lb0[w_x_eff];
        w_lb1_rd = r_lb1[w_x_eff];
        if (w_x_eff == XW'(WIDTH - 1)) begin
            w_x_next  = {XW{1'b0}};
            w_rc_next = (w_rc_eff == 2'd2) ? 2'd2 : w_rc_eff + 2'd1;
        end else begin
            w_x_next  = w_x_eff + {{(XW-1){1'b0}}, 1'b1};
            w_rc_next = w_rc_eff;
        end
        if (w_x_eff >= XW'(2)) begin
            w_wcol = 2'd2;
        end else begin
            w_wcol = w_x_eff[1:0];
        end
    end

    // Line buffers hold the two previous rows; contents are never reset because rc gates them.
    always_ff @(posedge clk) begin
        if (r_s1_valid) begin
            r_lb1[w_x_eff] <= w_lb0_rd;
            r_lb0[w_x_eff] <= r_s1_y;
        end
    end

    // S2 register: counters, fill state and the 3x3 window (row 0 = oldest, column 2 = newest).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x        <= {XW{1'b0}};
            r_rc       <= 2'd0;
            r_s2_wcol  <= 2'd0;
            r_s2_rc    <= 2'd0;
            r_s2_valid <= 1'b0;
            r_s2_pass  <= 24'd0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[i][j] <= 8'd0;
                end
            end
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_pass  <= r_s1_pass;
            if (r_s1_valid) begin
                r_x       <= w_x_next;
                r_rc      <= w_rc_next;
                r_s2_wcol <= w_wcol;
                r_s2_rc   <= w_rc_eff;
                for (int i = 0; i < 3; i++) begin
                    r_win[i][0] <= r_win[i][1];
                    r_win[i][1] <= r_win[i][2];
                end
                r_win[0][2] <= w_lb1_rd;
                r_win[1][2] <= w_lb0_rd;
                r_win[2][2] <= r_s1_y;
            end
        end
    end

    // Sobel on the window centre; each gradient spans -1020..1020, so |Gx|+|Gy| fits 12 bits.
    always_comb begin
        w_gx_pos = {2'b00, r_win[0][2]} + {1'b0, r_win[1][2], 1'b0} + {2'b00, r_win[2][2]};
        w_gx_neg = {2'b00, r_win[0][0]} + {1'b0, r_win[1][0], 1'b0} + {2'b00, r_win[2][0]};
        w_gy_pos = {2'b00, r_win[2][0]} + {1'b0, r_win[2][1], 1'b0} + {2'b00, r_win[2][2]};
        w_gy_neg = {2'b00, r_win[0][0]} + {1'b0, r_win[0][1], 1'b0} + {2'b00, r_win[0][2]};
        w_gx     = $signed({1'b0, w_gx_pos}) - $signed({1'b0, w_gx_neg});
        w_gy     = $signed({1'b0, w_gy_pos}) - $signed({1'b0, w_gy_neg});
        w_gx_abs = w_gx[10] ? $unsigned(-w_gx) : $unsigned(w_gx);
        w_gy_abs = w_gy[10] ? $unsigned(-w_gy) : $unsigned(w_gy);
        w_mag    = {1'b0, w_gx_abs} + {1'b0, w_gy_abs};
        w_edge   = en && (r_s2_wcol == 2'd2) && (r_s2_rc == 2'd2) &&
                   (w_mag > {2'b00, thresh, 2'b00});
    end

    // S3 output register: edge flag holds across input gaps, side channel always advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            edge_out  <= 8'h00;
            pass_thru <= 24'd0;
        end else begin
            out_valid <= r_s2_valid;
            pass_thru <= r_s2_pass;
            if (r_s2_valid) begin
                edge_out <= w_edge ? 8'hFF : 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_cartoon_edge_detect.sv
// Self-checking bench for cartoon_edge_detect: directed images plus random frames,
// compared against an image-level Sobel model with a 3-step output delay.
module tb_cartoon_edge_detect;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic        in_sof;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [7:0]  thresh;
    logic        out_valid;
    logic [7:0]  edge_out;
    logic [23:0] pass_in;
    logic [23:0] pass_thru;

    always #5 clk = ~clk;

    cartoon_edge_detect #(.WIDTH(W), .XW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .r         (r),
        .g         (g),
        .b         (b),
        .thresh    (thresh),
        .out_valid (out_valid),
        .edge_out  (edge_out),
        .pass_in   (pass_in),
        .pass_thru (pass_thru)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          k       = 0;
    int          mx      = 0;
    int          my      = 0;
    int          ff_count = 0;
    int          img [64][W];
    logic        h_valid [4096];
    logic        h_rst   [4096];
    logic        h_en    [4096];
    int          h_mag   [4096];
    int          h_th    [4096];
    logic [23:0] h_pass  [4096];
    logic [7:0]  last_edge = 8'h00;

    // Sobel magnitude of the image centred on (xx-1, yy-1), i.e. the window ending at (xx, yy).
    function automatic int sobel_mag(input int yy, input int xx);
        int gx;
        int gy;
        gx = (img[yy-2][xx] + 2*img[yy-1][xx] + img[yy][xx])
           - (img[yy-2][xx-2] + 2*img[yy-1][xx-2] + img[yy][xx-2]);
        gy = (img[yy][xx-2] + 2*img[yy][xx-1] + img[yy][xx])
           - (img[yy-2][xx-2] + 2*img[yy-2][xx-1] + img[yy-2][xx]);
        return ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
    endfunction

    task automatic check_outputs();
        logic        ev;
        logic [23:0] ep;
        bit          zap;
        zap = h_rst[k];
        if (k < 2) zap = 1'b1;
        else if (h_rst[k-1] || h_rst[k-2]) zap = 1'b1;
        if (zap) begin
            ev = 1'b0;
            ep = 24'd0;
            if (h_rst[k] || (k >= 1 && h_rst[k-1]) || k < 2) last_edge = 8'h00;
        end else begin
            ev = h_valid[k-2];
            ep = h_pass[k-2];
            if (ev) last_edge = (h_en[k] && h_mag[k-2] > 4 * h_th[k]) ? 8'hFF : 8'h00;
        end
        n_tests++;
        assert (out_valid === ev) else begin
            n_fail++;
            $error("FAIL out_valid step=%0d got=%b exp=%b", k, out_valid, ev);
        end
        n_tests++;
        assert (pass_thru === ep) else begin
            n_fail++;
            $error("FAIL pass_thru step=%0d got=%h exp=%h", k, pass_thru, ep);
        end
        n_tests++;
        assert (edge_out === last_edge) else begin
            n_fail++;
            $error("FAIL edge_out step=%0d got=%h exp=%h", k, edge_out, last_edge);
        end
        if (out_valid === 1'b1 && edge_out === 8'hFF) ff_count++;
    endtask

    task automatic step(input logic v, input logic s, input logic [7:0] rr,
                        input logic [7:0] gg, input logic [7:0] bb, input logic rs);
        int y;
        in_valid = v;
        in_sof   = s;
        r        = rr;
        g        = gg;
        b        = bb;
        rst      = rs;
        pass_in  = 24'($urandom);
        h_pass[k]  = pass_in;
        h_rst[k]   = rs;
        h_en[k]    = en;
        h_th[k]    = int'(thresh);
        h_valid[k] = v && !rs;
        h_mag[k]   = -1;
        if (rs) begin
            mx = 0;
            my = 0;
        end else if (v) begin
            if (s) begin
                mx = 0;
                my = 0;
            end
            y = (77 * int'(rr) + 150 * int'(gg) + 29 * int'(bb)) / 256;
            img[my][mx] = y;
            if (mx >= 2 && my >= 2) h_mag[k] = sobel_mag(my, mx);
            mx++;
            if (mx == W) begin
                mx = 0;
                if (my < 63) my++;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
        k++;
    endtask

    task automatic step_pixel(input int kind, input int col, input logic s);
        logic [7:0] v;
        if (kind == 0) begin
            step(1'b1, s, 8'd100, 8'd100, 8'd100, 1'b0);
        end else if (kind == 1) begin
            v = (col < 4) ? 8'd0 : 8'd255;
            step(1'b1, s, v, v, v, 1'b0);
        end else begin
            step(1'b1, s, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        end
    endtask

    // kind: 0 flat grey, 1 black/white step, 2 random; gapmode: 0 none, 1 alternate, 2 random.
    task automatic send_frame(input int kind, input int rows, input int gapmode, input int sof_at);
        for (int p = 0; p < rows * W; p++) begin
            step_pixel(kind, p % W, (p == 0) || (p == sof_at));
            if (gapmode == 1 || (gapmode == 2 && $urandom_range(0, 3) == 0)) begin
                step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
            end
        end
        repeat (4) step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    endtask

    task automatic check_ff(input string tag, input int exp);
        n_tests++;
        assert (ff_count == exp) else begin
            n_fail++;
            $error("FAIL %s ff_count got=%0d exp=%0d", tag, ff_count, exp);
        end
        ff_count = 0;
    endtask

    initial begin
        en       = 1'b1;
        thresh   = 8'd32;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        r        = 8'd0;
        g        = 8'd0;
        b        = 8'd0;
        pass_in  = 24'd0;
        step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
        step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
        ff_count = 0;

        send_frame(0, 6, 0, -1);
        check_ff("flat", 0);

        send_frame(1, 5, 0, -1);
        check_ff("step", 6);

        thresh = 8'd255;
        send_frame(1, 5, 0, -1);
        check_ff("step_th255", 0);
        thresh = 8'd32;

        send_frame(1, 5, 1, -1);
        check_ff("step_gaps", 6);

        en = 1'b0;
        send_frame(1, 5, 0, -1);
        check_ff("step_en0", 0);
        en = 1'b1;

        // Reset in the middle of row 3, then restart without sof.
        for (int p = 0; p < 3 * W + 4; p++) step_pixel(1, p % W, p == 0);
        step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
        for (int p = 0; p < 5 * W; p++) step_pixel(1, p % W, 1'b0);
        repeat (4) step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
        check_ff("mid_reset", 8);

        thresh = 8'd0;
        send_frame(1, 4, 0, -1);
        check_ff("thresh0", 4);

        for (int f = 0; f < 6; f++) begin
            thresh = 8'($urandom_range(0, 255));
            en     = (f != 4);
            send_frame(2, 6, (f % 3 == 1) ? 2 : 0, (f == 2) ? 27 : -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
